operand_stage_legv8: RTL

Operand-fetch stage that sits directly upstream of the 64-bit LEGv8 ALU. It holds the 32×64 architectural register file and selects the A/B operands, with B taken from the register file or an immediate. Operands, FS and C0 are registered into a one-entry valid/ready output buffer that drives the ALU. It also holds the architectural NZCV flag register, which captures the ALU's 4-bit status on flag-setting operations.

---
 rtl/operand_stage_legv8.sv | 123 ++++++++++++
 1 files changed

// File: rtl/operand_stage_legv8.sv
// ----------------------------------------------------------------------------
// operand_stage_legv8
//   Operand-fetch stage in front of the 64-bit LEGv8 ALU. Holds the REGSxN
//   architectural register file (top index is XZR, reads as zero, ignores
//   writes), picks operand A = reg[SA] and B = imm or reg[SB], and registers
//   {A, B, FS, C0} into a one-entry valid/ready buffer that feeds the ALU.
//   Also holds the NZCV flag register, loaded from the ALU status on flag_we.
//
// Optional feature macro: OPSTAGE_BYPASS_EN
//   Defined   : a same-cycle register write to SA/SB is forwarded into A/B.
//   Undefined : A/B capture the pre-write value; a hazard bubble is needed.
//
// Ports
//   clock, reset_n          rising-edge clock, synchronous active-low reset
//   in_valid / in_ready     request handshake from decode
//   SA, SB, imm, use_imm    operand selection
//   FS_in, C0_in            ALU function select / carry-in, passed through
//   wb_en, wb_addr, wb_data register-file write port (handshake independent)
//   out_valid / out_ready   handshake to the ALU
//   A, B, FS, C0            registered ALU operands and controls
//   status_in, flag_we      ALU status {V,C,N,Z} and its capture enable
//   flags                   architectural NZCV, bit order {V,C,N,Z}
// ----------------------------------------------------------------------------
module operand_stage_legv8 #(
   parameter int N    = 64,
   parameter int REGS = 32
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [4:0]   SA,
   input  logic [4:0]   SB,
   input  logic [N-1:0] imm,
   input  logic         use_imm,
   input  logic [4:0]   FS_in,
   input  logic         C0_in,
   input  logic         wb_en,
   input  logic [4:0]   wb_addr,
   input  logic [N-1:0] wb_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] A,
   output logic [N-1:0] B,
   output logic [4:0]   FS,
   output logic         C0,
   input  logic [3:0]   status_in,
   input  logic         flag_we,
   output logic [3:0]   flags
);

   localparam logic [4:0] XZR = 5'(REGS - 1);

   typedef struct packed {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [4:0]   fs;
      logic         c0;
   } op_t;

   logic [N-1:0] rf [REGS];
   op_t          out_q;
   op_t          nxt;
   logic [N-1:0] rd_a, rd_b;
   logic         accept;
   logic         wb_live;

   // XZR is gated on read as well, so it reads zero no matter what the
   // storage slot holds.
   assign rd_a    = (SA == XZR) ? '0 : rf[SA];
   assign rd_b    = (SB == XZR) ? '0 : rf[SB];
   assign wb_live = wb_en && (wb_addr != XZR);

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      nxt    = '0;
      nxt.fs = FS_in;
      nxt.c0 = C0_in;
`ifdef OPSTAGE_BYPASS_EN
      // Forward the in-flight write so back-to-back dependent ops need no
      // bubble; XZR never forwards because wb_live excludes it.
      nxt.a = (wb_live && wb_addr == SA) ? wb_data : rd_a;
      if (use_imm)
         nxt.b = imm;
      else
         nxt.b = (wb_live && wb_addr == SB) ? wb_data : rd_b;
`else
      nxt.a = rd_a;
      nxt.b = use_imm ? imm : rd_b;
`endif
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         for (int i = 0; i < REGS; i++)
            rf[i] <= '0;
         out_q     <= '0;
         out_valid <= 1'b0;
         flags     <= '0;
      end else begin
         if (wb_live)
            rf[wb_addr] <= wb_data;
         // Buffer only loads on accept, so a stall holds the captured
         // operands even if their source registers are rewritten.
         if (accept) begin
            out_q     <= nxt;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (flag_we)
            flags <= status_in;
      end
   end

   assign A  = out_q.a;
   assign B  = out_q.b;
   assign FS = out_q.fs;
   assign C0 = out_q.c0;

endmodule
